// File: rtl/uart_ser_pkg.sv
// Shared types and constants for the UART word serializer.
package uart_ser_pkg;

  localparam int CPB_MIN = 2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_e;

  // The reserved encoding 3 falls back to no parity.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return EVEN;
      2'd2:    return ODD;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_ser_fifo.sv
// Synchronous word FIFO with occupancy output and same-cycle push/pop.
module uart_ser_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [WORD_W-1:0]        rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   level_nx_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              full;
  logic              wr_en;
  logic              rd_en;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign wr_en   = push_i && (!full || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_nx_o = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_nx_o = level_q + LVL_W'(1);
      2'b01:   level_nx_o = level_q - LVL_W'(1);
      default: level_nx_o = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_nx_o;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level alone define
  // validity, so resetting the array would only cost flops and routing.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_word_serializer.sv
// Buffers full-width words and transmits them LSB byte first as
// back-to-back UART frames with runtime bit period, parity and stop bits.
module uart_word_serializer
  import uart_ser_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int CPB_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CPB_W-1:0]       cfg_cpb_i,
  input  logic [1:0]             cfg_parity_i,
  input  logic                   cfg_stop2_i,
  input  logic                   in_valid_i,
  input  logic [WORD_W-1:0]      in_data_i,
  output logic                   in_ready_o,
  output logic                   tx_o,
  output logic                   txen_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [31:0]            frame_cnt_o
);

  localparam int NBYTES = WORD_W / 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NBYTES - 1);

  ser_state_e        state_q, state_d;
  logic [CPB_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [BI_W-1:0]   byte_q, byte_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CPB_W-1:0]  cpb_q, cpb_d;
  parity_e           par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              txen_q, busy_q, ready_q;
  logic [31:0]       frame_cnt_q;

  logic              pop, frame_done, tick, push;
  logic [CPB_W-1:0]  cpb_in, reload;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level_nx;

  // Ready is forced low while reset is held; its registered value is 1 after reset.
  assign in_ready_o = ready_q && !rst_i;
  assign push       = in_valid_i && in_ready_o;
  assign tick       = (cnt_q == '0);
  assign reload     = cpb_q - CPB_W'(1);
  assign cpb_in     = (cfg_cpb_i < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : cfg_cpb_i;

  uart_ser_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .wdata_i    (in_data_i),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level_o),
    .level_nx_o (fifo_level_nx)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CPB_W'(1);
    bit_d      = bit_q;
    stop_d     = stop_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    cpb_d      = cpb_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: pop = !fifo_empty;
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
        cnt_d   = reload;
      end
      DATA: if (tick) begin
        cnt_d = reload;
        if (bit_q == 3'd7) begin
          state_d = (par_q == NONE) ? STOP : PARITY;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        stop_d  = 1'b0;
        cnt_d   = reload;
      end
      STOP: if (tick) begin
        if (stop2_q && !stop_q) begin
          stop_d = 1'b1;
          cnt_d  = reload;
        end else begin
          frame_done = 1'b1;
          if (byte_q != LAST_BYTE) begin
            shift_d = shift_q >> 8;
            byte_d  = byte_q + BI_W'(1);
            state_d = START;
            cnt_d   = reload;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Configuration is captured only when a word is popped, so it holds for the whole word.
    if (pop) begin
      state_d = START;
      shift_d = fifo_rdata;
      cpb_d   = cpb_in;
      par_d   = decode_parity(cfg_parity_i);
      stop2_d = cfg_stop2_i;
      byte_d  = '0;
      cnt_d   = cpb_in - CPB_W'(1);
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      PARITY:  tx_d = (^shift_d[7:0]) ^ (par_d == ODD);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      byte_q      <= '0;
      shift_q     <= '0;
      cpb_q       <= CPB_W'(CPB_MIN);
      par_q       <= NONE;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      txen_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      cpb_q   <= cpb_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      txen_q  <= (state_d != IDLE);
      busy_q  <= (state_d != IDLE) || (fifo_level_nx != '0);
      ready_q <= (fifo_level_nx != LVL_W'(DEPTH));
      if (frame_done) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign tx_o        = tx_q;
  assign txen_o      = txen_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
